contador_modulo_ud: RTL and testbench
=====================================

CONTADOR_MODULO_UD -- requirements
Module: contador_modulo_ud

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits (1..32).
REQ-002 The block SHALL have parameter MODULO, default 10, count range 0..MODULO-1; legal range is 2 <= MODULO <= 2**WIDTH.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates occur on the falling edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1, count permission; 0 holds cuenta.
REQ-006 The block SHALL have port up, input, 1, direction select; 1 counts up, 0 counts down.
REQ-007 The block SHALL have port clr, input, 1, synchronous clear to 0.
REQ-008 The block SHALL have port load, input, 1, synchronous load of dato.
REQ-009 The block SHALL have port dato, input, WIDTH, load value.
REQ-010 The block SHALL have port cuenta, output, WIDTH, current count, driven directly from the state register.
REQ-011 The block SHALL have port tc, output, 1, combinational terminal-count indicator.
REQ-012 The block SHALL have port desborde, output, 1, registered sticky wrap/limit flag.

Function
REQ-013 The block SHALL apply next-state priority per falling clk edge: clr > load > enable > hold.
REQ-014 The block SHALL set cuenta to 0 and desborde to 0 on clr=1, regardless of the other inputs.
REQ-015 The block SHALL, on load=1 with clr=0, set cuenta to dato when dato <= MODULO-1, else to MODULO-1; desborde is unchanged.
REQ-016 The block SHALL, on enable=1 with up=1, advance cuenta by 1; at cuenta=MODULO-1 it wraps to 0.
REQ-017 The block SHALL, on enable=1 with up=0, decrement cuenta by 1; at cuenta=0 it wraps to MODULO-1.
REQ-018 The block SHALL hold cuenta when enable=0, clr=0 and load=0; up changes alone have no effect.
REQ-019 The block SHALL assert tc=1 only when enable=1, clr=0, load=0 and either (up=1, cuenta=MODULO-1) or (up=0, cuenta=0); otherwise tc=0.
REQ-020 The block SHALL set desborde to 1 on every clock edge where tc=1; desborde stays 1 until clr or reset.
REQ-021 The block SHALL have a latency of one falling edge from input to the cuenta/desborde update; tc responds combinationally within the same cycle.
REQ-022 The block SHALL compute all arithmetic at WIDTH bits with no intermediate overflow; with MODULO=2**WIDTH, the wrap coincides with natural binary rollover.

Reset
REQ-023 The block SHALL force cuenta=0 and desborde=0 immediately while rst=0, independent of clk.
REQ-024 The block SHALL keep tc=0 while rst=0, because cuenta=0 and the count is held.
REQ-025 The block SHALL resume counting on the first falling clk edge after rst returns to 1; reset mid-count discards the count with no residual state.

Configuration
REQ-026 The block SHALL support macro CONTADOR_SATURATE_EN.
- Defined: at the limit (up at MODULO-1, down at 0), cuenta holds instead of wrapping; tc and desborde behave as in REQ-019/020.
- Undefined: wrap-around per REQ-016/017.
REQ-027 The block SHALL keep clr, load and reset behaviour identical in both configurations.

Verification (WIDTH=4, MODULO=10 unless stated)
REQ-028 The bench SHALL cover: reset release, enable=1, up=1, 12 edges -> cuenta 1..9,0,1,2; tc=1 only while cuenta=9; desborde=1 after the 10th edge.
REQ-029 The bench SHALL cover: load dato=3, then up=0, enable=1, 5 edges -> cuenta 2,1,0,9,8; tc=1 while cuenta=0.
REQ-030 The bench SHALL cover: load dato=15 -> cuenta=9; then clr=1 and load=1 on the same edge -> cuenta=0, desborde=0.
REQ-031 The bench SHALL cover: rst pulled low between clk edges at cuenta=7 -> cuenta=0 with no clk edge; enable held at 1 -> cuenta counts 1 on the first falling edge after release.
REQ-032 The bench SHALL cover: CONTADOR_SATURATE_EN defined, up=1 from 8, 4 edges -> cuenta 9,9,9,9; tc=1 from cuenta=9; desborde=1.
REQ-033 The bench SHALL cover: WIDTH=4, MODULO=16, up=1 from 15 -> cuenta=0, tc=1 at 15; enable=0 at cuenta=15 -> tc=0 and cuenta holds.

Source files
------------

// File: rtl/contador_modulo_ud.sv
// Up/down modulo counter, falling-edge state, async active-low reset.
// Optional: define CONTADOR_SATURATE_EN to hold at the limit instead of wrapping.
module contador_modulo_ud #(
  parameter int     WIDTH  = 4,
  parameter longint MODULO = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] dato,
  output logic [WIDTH-1:0] cuenta,
  output logic             tc,
  output logic             desborde
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);

`ifdef CONTADOR_SATURATE_EN
  localparam logic [WIDTH-1:0] AFTER_TOP = MAXV;
  localparam logic [WIDTH-1:0] AFTER_BOT = '0;
`else
  localparam logic [WIDTH-1:0] AFTER_TOP = '0;
  localparam logic [WIDTH-1:0] AFTER_BOT = MAXV;
`endif

  logic [WIDTH-1:0] r_cuenta;
  logic             r_desborde;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;
  logic             w_top;
  logic             w_bot;
  logic             w_tc;

  assign w_top = up && (r_cuenta == MAXV);
  assign w_bot = !up && (r_cuenta == '0);

  // rst gating keeps tc quiet while the count is forced to zero
  assign w_tc = rst && enable && !clr && !load && (w_top || w_bot);

  assign w_load_val = (dato > MAXV) ? MAXV : dato;

  always_comb begin
    w_next = r_cuenta;
    if (clr) begin
      w_next = '0;
    end else if (load) begin
      w_next = w_load_val;
    end else if (enable) begin
      if (up) begin
        w_next = w_top ? AFTER_TOP : r_cuenta + WIDTH'(1);
      end else begin
        w_next = w_bot ? AFTER_BOT : r_cuenta - WIDTH'(1);
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_cuenta   <= '0;
      r_desborde <= 1'b0;
    end else begin
      r_cuenta <= w_next;
      if (clr) begin
        r_desborde <= 1'b0;
      end else if (w_tc) begin
        r_desborde <= 1'b1;
      end
    end
  end

  assign cuenta   = r_cuenta;
  assign tc       = w_tc;
  assign desborde = r_desborde;

endmodule

// File: tb/tb_contador_modulo_ud.sv
// Directed bench for contador_modulo_ud: one 4-bit/mod-10 and one
// 4-bit/mod-16 instance; expectations follow CONTADOR_SATURATE_EN.
module tb_contador_modulo_ud;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       en, up, clr, load;
  logic [3:0] dato;
  logic [3:0] cuenta;
  logic       tc, desb;

  logic       en16, up16, clr16, load16;
  logic [3:0] dato16;
  logic [3:0] cuenta16;
  logic       tc16, desb16;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  contador_modulo_ud #(.WIDTH(4), .MODULO(10)) u_dut (
    .clk(clk), .rst(rst), .enable(en), .up(up), .clr(clr),
    .load(load), .dato(dato), .cuenta(cuenta), .tc(tc),
    .desborde(desb)
  );

  contador_modulo_ud #(.WIDTH(4), .MODULO(16)) u_dut16 (
    .clk(clk), .rst(rst), .enable(en16), .up(up16), .clr(clr16),
    .load(load16), .dato(dato16), .cuenta(cuenta16), .tc(tc16),
    .desborde(desb16)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; dato = 4'd0;
    en16 = 1'b0; up16 = 1'b0; clr16 = 1'b0; load16 = 1'b0;
    dato16 = 4'd0;
    #2 rst = 1'b0;
    #1;
    ntests++;
    if (cuenta !== 4'd0) begin
      nfail++; $display("FAIL reset_cuenta: got %0d want 0", cuenta);
    end
    ntests++;
    if (desb !== 1'b0) begin
      nfail++; $display("FAIL reset_desborde: got %0b want 0", desb);
    end
    en = 1'b1;
    step();
    ntests++;
    if (cuenta !== 4'd0 || cuenta16 !== 4'd0) begin
      nfail++;
      $display("FAIL reset_hold: got %0d/%0d want 0/0", cuenta, cuenta16);
    end
    ntests++;
    if (tc !== 1'b0) begin
      nfail++; $display("FAIL reset_tc: got %0b want 0", tc);
    end
  endtask

  task automatic test_count_up();
    int cur = 0;
    rst = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      ntests++;
      if (tc !== (cur == 9)) begin
        nfail++;
        $display("FAIL up_tc[%0d]: got %0b want %0b", i, tc, cur == 9);
      end
      step();
      cur = (cur + 1) % 10;
      ntests++;
      if (cuenta !== 4'(cur) || desb !== (i >= 10)) begin
        nfail++;
        $display("FAIL up_cnt[%0d]: got %0d/%0b want %0d/%0b",
                 i, cuenta, desb, cur, i >= 10);
      end
    end
  endtask

  task automatic test_load_down();
    logic [3:0] exp_seq [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    int cur;
    clr = 1'b1;
    step();
    clr = 1'b0;
    ntests++;
    if (cuenta !== 4'd0 || desb !== 1'b0) begin
      nfail++;
      $display("FAIL clr: got %0d/%0b want 0/0", cuenta, desb);
    end
    load = 1'b1; dato = 4'd3;
    step();
    load = 1'b0; up = 1'b0;
    ntests++;
    if (cuenta !== 4'd3) begin
      nfail++; $display("FAIL load3: got %0d want 3", cuenta);
    end
    cur = 3;
    for (int i = 0; i < 5; i++) begin
      ntests++;
      if (tc !== (cur == 0)) begin
        nfail++;
        $display("FAIL dn_tc[%0d]: got %0b want %0b", i, tc, cur == 0);
      end
      step();
      cur = int'(exp_seq[i]);
      ntests++;
      if (cuenta !== exp_seq[i]) begin
        nfail++;
        $display("FAIL dn_cnt[%0d]: got %0d want %0d", i, cuenta, exp_seq[i]);
      end
    end
    ntests++;
    if (desb !== 1'b1) begin
      nfail++; $display("FAIL dn_desborde: got %0b want 1", desb);
    end
  endtask

  task automatic test_clamp_clr();
    en = 1'b0; load = 1'b1; dato = 4'd15;
    step();
    ntests++;
    if (cuenta !== 4'd9 || desb !== 1'b1) begin
      nfail++;
      $display("FAIL clamp: got %0d/%0b want 9/1", cuenta, desb);
    end
    en = 1'b1; up = 1'b1; clr = 1'b1; load = 1'b1; dato = 4'd5;
    #1;
    ntests++;
    if (tc !== 1'b0) begin
      nfail++; $display("FAIL clr_tc: got %0b want 0", tc);
    end
    step();
    ntests++;
    if (cuenta !== 4'd0 || desb !== 1'b0) begin
      nfail++;
      $display("FAIL clr_load: got %0d/%0b want 0/0", cuenta, desb);
    end
    clr = 1'b0; load = 1'b1; dato = 4'd9;
    step();
    load = 1'b1;
    #1;
    ntests++;
    if (tc !== 1'b0) begin
      nfail++; $display("FAIL load_tc: got %0b want 0", tc);
    end
    load = 1'b0;
  endtask

  task automatic test_hold();
    en = 1'b0; up = 1'b1;
    #1;
    ntests++;
    if (tc !== 1'b0) begin
      nfail++; $display("FAIL hold_tc: got %0b want 0", tc);
    end
    step();
    up = 1'b0;
    step();
    ntests++;
    if (cuenta !== 4'd9 || desb !== 1'b0) begin
      nfail++;
      $display("FAIL hold: got %0d/%0b want 9/0", cuenta, desb);
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; dato = 4'd7;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    ntests++;
    if (cuenta !== 4'd7) begin
      nfail++; $display("FAIL mid_load: got %0d want 7", cuenta);
    end
    #2 rst = 1'b0;
    #1;
    ntests++;
    if (cuenta !== 4'd0 || desb !== 1'b0) begin
      nfail++;
      $display("FAIL mid_rst: got %0d/%0b want 0/0", cuenta, desb);
    end
    #1 rst = 1'b1;
    step();
    ntests++;
    if (cuenta !== 4'd1) begin
      nfail++; $display("FAIL mid_resume: got %0d want 1", cuenta);
    end
  endtask

  task automatic test_saturate();
`ifdef CONTADOR_SATURATE_EN
    logic [3:0] exp_seq [4] = '{4'd9, 4'd9, 4'd9, 4'd9};
`else
    logic [3:0] exp_seq [4] = '{4'd9, 4'd0, 4'd1, 4'd2};
`endif
    int cur;
    en = 1'b0; load = 1'b1; dato = 4'd8;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    cur = 8;
    for (int i = 0; i < 4; i++) begin
      ntests++;
      if (tc !== (cur == 9)) begin
        nfail++;
        $display("FAIL sat_tc[%0d]: got %0b want %0b", i, tc, cur == 9);
      end
      step();
      cur = int'(exp_seq[i]);
      ntests++;
      if (cuenta !== exp_seq[i]) begin
        nfail++;
        $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, cuenta, exp_seq[i]);
      end
    end
    ntests++;
    if (desb !== 1'b1) begin
      nfail++; $display("FAIL sat_desborde: got %0b want 1", desb);
    end
  endtask

  task automatic test_mod16();
`ifdef CONTADOR_SATURATE_EN
    logic [3:0] exp_wrap = 4'd15;
`else
    logic [3:0] exp_wrap = 4'd0;
`endif
    load16 = 1'b1; dato16 = 4'd15;
    step();
    load16 = 1'b0; en16 = 1'b1; up16 = 1'b1;
    #1;
    ntests++;
    if (cuenta16 !== 4'd15 || tc16 !== 1'b1) begin
      nfail++;
      $display("FAIL m16_top: got %0d/%0b want 15/1", cuenta16, tc16);
    end
    step();
    ntests++;
    if (cuenta16 !== exp_wrap || desb16 !== 1'b1) begin
      nfail++;
      $display("FAIL m16_wrap: got %0d/%0b want %0d/1",
               cuenta16, desb16, exp_wrap);
    end
    clr16 = 1'b1;
    step();
    clr16 = 1'b0; load16 = 1'b1; dato16 = 4'd15;
    step();
    load16 = 1'b0; en16 = 1'b0;
    #1;
    ntests++;
    if (tc16 !== 1'b0) begin
      nfail++; $display("FAIL m16_hold_tc: got %0b want 0", tc16);
    end
    step();
    ntests++;
    if (cuenta16 !== 4'd15 || desb16 !== 1'b0) begin
      nfail++;
      $display("FAIL m16_hold: got %0d/%0b want 15/0", cuenta16, desb16);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_down();
    test_clamp_clr();
    test_hold();
    test_reset_mid();
    test_saturate();
    test_mod16();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
